// File: rtl/fir_pkg.sv
// Shared definitions for the FIR front end: default sample width,
// feeder state encoding and the signed sample type used by firfilter.
package fir_pkg;

    localparam int FIR_DATA_SIZE = 9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } feeder_state_t;

    typedef logic signed [FIR_DATA_SIZE-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and an occupancy count.
// full/empty are derived from the registered count.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Sample storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally on the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_sample_feeder.sv
// Paces FIFO-buffered producer samples into firfilter as one-cycle
// data/data_ready strobes every SAMPLE_PERIOD clocks, flagging underruns.
// Optional feature macro: FIR_FEEDER_ZERO_FILL_EN (zero-valued strobe on underrun).
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int DATA_SIZE     = FIR_DATA_SIZE,
    parameter int FIFO_DEPTH    = 8,
    parameter int SAMPLE_PERIOD = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic signed [DATA_SIZE-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [DATA_SIZE-1:0] data,
    output logic                        data_ready,
    output logic                        underrun
);

    localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

    feeder_state_t               state;
    feeder_state_t               state_next;
    logic [CW-1:0]               cnt;
    logic                        full;
    logic                        empty;
    logic                        push;
    logic                        pop;
    logic                        tick;
    logic                        start;
    logic signed [DATA_SIZE-1:0] head;

    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = tick && !empty;

    sync_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // Feeder state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; a tick exists only in RUN with enable high at counter zero.
    always_comb begin
        state_next = state;
        tick       = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !empty) begin
                    state_next = RUN;
                    start      = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    tick = (cnt == '0);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Period counter, registered outputs and sticky underrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            data       <= '0;
            data_ready <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            if (start) begin
                cnt <= '0;
            end else if (state == RUN && enable) begin
                cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
            end
            if (tick) begin
                if (!empty) begin
                    data       <= head;
                    data_ready <= 1'b1;
                end else begin
                    underrun <= 1'b1;
`ifdef FIR_FEEDER_ZERO_FILL_EN
                    data       <= '0;
                    data_ready <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_fir_sample_feeder;

    localparam int DW    = 9;
    localparam int DEPTH = 8;
    localparam int P     = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic                 in_valid;
    logic                 in_ready;
    logic                 data_ready;
    logic                 underrun;
    logic signed [DW-1:0] in_data;
    logic signed [DW-1:0] data;

    int checks   = 0;
    int failures = 0;

    // Reference model state: queued samples, running flag, phase since start.
    logic signed [DW-1:0] q[$];
    bit                   running;
    int                   phase;
    logic signed [DW-1:0] m_data;
    bit                   m_ready;
    bit                   m_under;
    bit                   accepted;

    always #5 clk = ~clk;

    fir_sample_feeder #(
        .DATA_SIZE     (DW),
        .FIFO_DEPTH    (DEPTH),
        .SAMPLE_PERIOD (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data       (data),
        .data_ready (data_ready),
        .underrun   (underrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        running = 1'b0;
        phase   = 0;
        m_data  = '0;
        m_ready = 1'b0;
        m_under = 1'b0;
    endtask

    task automatic compare(input string tag);
        check({tag, ".data"}, data, m_data);
        check({tag, ".data_ready"}, data_ready, m_ready);
        check({tag, ".underrun"}, underrun, m_under);
        check({tag, ".in_ready"}, in_ready, (q.size() < DEPTH));
    endtask

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic cycle(input bit en, input bit v, input logic signed [DW-1:0] d);
        int  size0;
        bit  do_push;
        bit  do_tick;
        enable   = en;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        size0   = q.size();
        do_push = v && (size0 < DEPTH);
        do_tick = running && en && (phase % P == 0);
        accepted = do_push;
        m_ready  = 1'b0;
        if (do_tick) begin
            if (size0 > 0) begin
                m_data  = q.pop_front();
                m_ready = 1'b1;
            end else begin
                m_under = 1'b1;
`ifdef FIR_FEEDER_ZERO_FILL_EN
                m_data  = '0;
                m_ready = 1'b1;
`endif
            end
        end
        if (do_push) q.push_back(d);
        if (running && !en) begin
            running = 1'b0;
        end else if (running) begin
            phase++;
        end else if (en && size0 > 0) begin
            running = 1'b1;
            phase   = 0;
        end
        #1;
        compare("cyc");
    endtask

    // Asynchronous reset pulse between edges, spanning one clock edge.
    task automatic pulse_reset();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare("rst_async");
        @(posedge clk);
        #1;
        compare("rst_hold");
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int idx;
        int rate;
        rst      = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        model_reset();
        #3;
        compare("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First sample latency and hold between strobes.
        cycle(1'b1, 1'b1, 9'sh010);
        cycle(1'b1, 1'b0, '0);
        check("lat_t1_idle", data_ready, 1'b0);
        cycle(1'b1, 1'b0, '0);
        check("lat_t2_strobe", data_ready, 1'b1);
        check("lat_t2_data", data, 32'h10);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 1'b0, '0);
            check("hold_quiet", data_ready, 1'b0);
            check("hold_data", data, 32'h10);
        end

        // Burst of 12 samples against a depth-8 FIFO.
        pulse_reset();
        idx = 0;
        n   = 0;
        for (int g = 0; g < 200 && idx < 12; g++) begin
            cycle(1'b1, 1'b1, DW'(16 + 5 * idx));
            if (accepted) idx++;
            if (data_ready) n++;
        end
        check("burst_accepted", idx, 12);
        for (int g = 0; g < 130; g++) begin
            cycle(1'b1, 1'b0, '0);
            if (data_ready && underrun == 1'b0) n++;
        end
        check("burst_strobes", n, 12);

        // Three samples then starve: underrun at the fourth tick.
        pulse_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, DW'(9'sh0A0 + i));
        for (int g = 0; g < 40; g++) cycle(1'b1, 1'b0, '0);
        check("starve_underrun", underrun, 1'b1);
`ifndef FIR_FEEDER_ZERO_FILL_EN
        check("starve_hold", data, 32'hA2);
`endif

        // Enable dropped after two strobes with four queued, then restored.
        pulse_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, DW'(9'sh030 + i));
        n = 1;
        for (int g = 0; g < 40 && n < 2; g++) begin
            cycle(1'b1, 1'b0, '0);
            if (data_ready) n++;
        end
        check("en_two_strobes", n, 2);
        n = 0;
        for (int g = 0; g < 15; g++) begin
            cycle(1'b0, 1'b0, '0);
            if (data_ready) n++;
        end
        check("en_low_quiet", n, 0);
        cycle(1'b1, 1'b0, '0);
        check("restore_no_strobe", data_ready, 1'b0);
        cycle(1'b1, 1'b0, '0);
        check("restore_strobe", data_ready, 1'b1);
        check("restore_data", data, 32'h32);

        // Reset mid-run with five queued and the counter at four.
        pulse_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, DW'(9'sh050 + i));
        pulse_reset();
        n = 0;
        for (int g = 0; g < 25; g++) begin
            cycle(1'b1, 1'b0, '0);
            if (data_ready) n++;
        end
        check("post_reset_quiet", n, 0);

        // Random traffic with varying producer rate, enable gaps and resets.
        rate = 4;
        for (int g = 0; g < 1500; g++) begin
            if (g % 100 == 0) rate = int'($urandom_range(1, 12));
            if ($urandom_range(0, 499) == 0) pulse_reset();
            cycle(($urandom_range(0, 19) != 0),
                  ($urandom_range(0, rate - 1) == 0),
                  DW'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
